// File: rtl/vga_sync_rx.sv
// ============================================================================
// vga_sync_rx : VGA receive monitor; rebuilds x/y/de/lock from HS/VS edges.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_rx #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [11:0] i_rgb,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic        o_pix_valid,
    output logic [11:0] o_rgb,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_err
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_HSS    = 10'(H_SYNC_START);
    localparam logic [9:0] C_HA     = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_VSS    = 10'(V_SYNC_START);
    localparam logic [9:0] C_VA     = 10'(V_ACTIVE);
    localparam logic [3:0] C_LOCK   = 4'(LOCK_FRAMES);

    logic [1:0] state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hs_prev_q, vs_prev_q;

    logic       w_hs_fall, w_vs_fall;
    logic [9:0] w_hn, w_vn;
    logic       w_bad;
    logic [3:0] w_good_inc;
    logic       w_locked_nxt, w_de, w_fs, w_err;

    assign w_hs_fall  = hs_prev_q & ~i_hs;
    assign w_vs_fall  = vs_prev_q & ~i_vs;
    assign w_hn       = (hcnt_q == C_H_LAST) ? 10'd0 : hcnt_q + 10'd1;
    assign w_vn       = (w_hn == 10'd0) ? ((vcnt_q == C_V_LAST) ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
    // A sync edge where none is expected, or a missing one, are both violations.
    assign w_bad      = (w_hs_fall ^ (w_hn == C_HSS)) |
                        (w_vs_fall ^ ((w_hn == 10'd0) && (w_vn == C_VSS)));
    assign w_good_inc = good_q + 4'd1;
    assign hcnt_d     = w_hs_fall ? C_HSS : w_hn;
    assign vcnt_d     = w_vs_fall ? C_VSS : w_vn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_SEARCH;
            good_q    <= 4'd0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else if (i_pix_stb) begin
            state_q   <= state_d;
            good_q    <= good_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hs_prev_q <= i_hs;
            vs_prev_q <= i_vs;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            S_SEARCH: begin
                if (w_vs_fall) begin
                    state_d = S_CHECK;
                    good_d  = 4'd0;
                end
            end
            S_CHECK: begin
                if (w_bad) begin
                    state_d = S_SEARCH;
                end else if (w_vs_fall) begin
                    good_d = (good_q == 4'hF) ? good_q : w_good_inc;
                    if (w_good_inc == C_LOCK) begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (w_bad) begin
                    state_d = S_SEARCH;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // Outputs describe the pixel sampled on this tick, hence the post-update counts.
    always_comb begin
        w_locked_nxt = (state_d == S_LOCKED);
        w_err        = w_bad & (state_q != S_SEARCH);
        w_de         = w_locked_nxt & (hcnt_d < C_HA) & (vcnt_d < C_VA);
        w_fs         = w_locked_nxt & (hcnt_d == 10'd0) & (vcnt_d == 10'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_de          <= 1'b0;
            o_pix_valid   <= 1'b0;
            o_rgb         <= 12'd0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end else if (i_pix_stb) begin
            o_x           <= w_de ? hcnt_d : 10'd0;
            o_y           <= w_de ? vcnt_d[8:0] : 9'd0;
            o_de          <= w_de;
            o_pix_valid   <= w_de;
            o_rgb         <= w_de ? i_rgb : 12'd0;
            o_locked      <= w_locked_nxt;
            o_frame_start <= w_fs;
            o_err         <= w_err;
        end else begin
            o_pix_valid   <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
// ============================================================================
// tb_vga_sync_rx : directed bench for vga_sync_rx on a scaled-down raster.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_rx;

    localparam int HA = 8, HSS = 10, HSW = 3, HT = 16;
    localparam int VA = 6, VSS = 8, VSW = 2, VT = 12;
    localparam int LF = 2;
    localparam int HS_LINE = 3;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pix_stb = 1'b0;
    logic        i_hs = 1'b1;
    logic        i_vs = 1'b1;
    logic [11:0] i_rgb = 12'd0;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_de, o_pix_valid, o_locked, o_frame_start, o_err;
    logic [11:0] o_rgb;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
        .i_hs(i_hs), .i_vs(i_vs), .i_rgb(i_rgb),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_pix_valid(o_pix_valid),
        .o_rgb(o_rgb), .o_locked(o_locked), .o_frame_start(o_frame_start),
        .o_err(o_err)
    );

    int n_cmp = 0, n_bad = 0;
    int gh = 0, gv = 0;
    bit shift_hs = 0, suppress_vs = 0, chk_px = 0, seen_pv = 0;
    int n_err = 0, n_pv = 0, n_fs = 0, n_de = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int err_h = -1, err_v = -1;
    logic locked_at_err = 1'bx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic gen_hs(input int h, input int v);
        int s;
        s = (shift_hs && v == HS_LINE) ? HSS + 1 : HSS;
        return !(h >= s && h < s + HSW);
    endfunction

    function automatic logic gen_vs(input int v);
        return suppress_vs || !(v >= VSS && v < VSS + VSW);
    endfunction

    function automatic logic [11:0] gen_rgb(input int h, input int v);
        return 12'(h * 29 + v * 113 + 7);
    endfunction

    // One pixel tick followed by one idle clock.
    task automatic do_tick();
        int ch, cv;
        logic [11:0] rgb;
        logic de_e;
        ch = gh; cv = gv;
        rgb = gen_rgb(gh, gv);
        i_hs = gen_hs(gh, gv);
        i_vs = gen_vs(gv);
        i_rgb = rgb;
        i_pix_stb = 1'b1;
        @(posedge clk); #1;
        i_pix_stb = 1'b0;
        if (o_err) begin n_err++; locked_at_err = o_locked; err_h = ch; err_v = cv; end
        if (o_frame_start) n_fs++;
        if (o_de) n_de++;
        if (o_pix_valid) begin
            if (!seen_pv) begin first_x = o_x; first_y = o_y; seen_pv = 1; end
            last_x = o_x; last_y = o_y; n_pv++;
        end
        if (chk_px) begin
            de_e = (ch < HA) && (cv < VA);
            chk("px_de", o_de, de_e);
            chk("px_valid", o_pix_valid, de_e);
            chk("px_x", o_x, de_e ? ch : 0);
            chk("px_y", o_y, de_e ? cv : 0);
            chk("px_rgb", o_rgb, de_e ? rgb : 12'd0);
            chk("px_fs", o_frame_start, (ch == 0 && cv == 0));
            chk("px_locked", o_locked, 1);
        end
        gh++;
        if (gh == HT) begin gh = 0; gv = (gv == VT - 1) ? 0 : gv + 1; end
        @(posedge clk); #1;
        chk("idle_pulses", {o_pix_valid, o_frame_start, o_err}, 3'b000);
    endtask

    task automatic run_until(input int h, input int v);
        int guard;
        guard = 0;
        while (!(gh == h && gv == v) && guard <= HT * VT) begin
            do_tick();
            guard++;
        end
        chk("run_until_reached", (gh == h && gv == v), 1);
    endtask

    // Three vs_falls from SEARCH: lock must appear exactly on the third.
    task automatic relock(input string tag);
        for (int i = 0; i < 3; i++) begin
            run_until(0, VSS);
            chk({tag, "_pre_lock"}, o_locked, 0);
            do_tick();
            chk({tag, "_post_lock"}, o_locked, (i == 2));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_de", o_de, 0);
        chk("rst_rgb", o_rgb, 0);
        chk("rst_pv", o_pix_valid, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_fs_err", {o_frame_start, o_err}, 2'b00);

        // Acquire lock with reset released mid-line.
        gh = 5; gv = 2;
        i_rst_n = 1'b1;
        relock("acq");
        chk("acq_no_err", n_err, 0);

        // One full locked frame, every pixel checked.
        run_until(0, 0);
        n_pv = 0; n_fs = 0; seen_pv = 0; chk_px = 1;
        run_until(HA, 0);
        do_tick();
        chk("de_low_at_x_active", o_de, 0);
        run_until(0, 0);
        chk("frame_pv_count", n_pv, HA * VA);
        chk("frame_fs_count", n_fs, 1);
        chk("first_xy", {first_x[15:0], first_y[15:0]}, {16'd0, 16'd0});
        chk("last_xy", {last_x[15:0], last_y[15:0]}, {16'(HA - 1), 16'(VA - 1)});
        do_tick();
        chk("next_fs", n_fs, 2);
        chk_px = 0;

        // HS one tick late on HS_LINE while locked.
        run_until(0, HS_LINE);
        shift_hs = 1;
        run_until(HSS, HS_LINE);
        n_err = 0;
        chk("hs_pre_locked", o_locked, 1);
        do_tick();
        chk("hs_err_count", n_err, 1);
        chk("hs_locked_at_err", locked_at_err, 0);
        chk("hs_locked_after", o_locked, 0);
        run_until(0, HS_LINE + 1);
        shift_hs = 0;
        n_de = 0;
        relock("hs");
        chk("hs_de_while_unlocked", n_de, 0);
        chk("hs_single_err", n_err, 1);

        // VS suppressed for one frame while locked.
        run_until(0, 0);
        suppress_vs = 1;
        run_until(0, VSS);
        n_err = 0;
        chk("vs_pre_locked", o_locked, 1);
        do_tick();
        chk("vs_err_count", n_err, 1);
        chk("vs_err_pos", {err_h[15:0], err_v[15:0]}, {16'd0, 16'(VSS)});
        chk("vs_locked_after", o_locked, 0);
        run_until(0, VSS + VSW);
        suppress_vs = 0;
        n_fs = 0;
        relock("vs");
        chk("vs_no_fs_unlocked", n_fs, 0);
        chk("vs_single_err", n_err, 1);

        // Asynchronous reset mid active line while locked.
        run_until(3, 2);
        do_tick();
        chk("prerst_de", o_de, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_de", o_de, 0);
        chk("arst_xy", {o_x, o_y}, 19'd0);
        chk("arst_rgb", o_rgb, 0);
        chk("arst_locked", o_locked, 0);
        @(posedge clk);
        @(posedge clk);
        #1 i_rst_n = 1'b1;
        n_err = 0;
        relock("rst");
        chk("rst_relock_no_err", n_err, 0);

        // Pixel strobe stalled mid-line.
        run_until(4, 1);
        do_tick();
        chk("stall_x0", o_x, 4);
        chk("stall_y0", o_y, 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            chk("stall_x", o_x, 4);
            chk("stall_y", o_y, 1);
            chk("stall_pv", o_pix_valid, 0);
        end
        n_err = 0;
        chk_px = 1;
        run_until(0, 0);
        do_tick();
        chk_px = 0;
        chk("stall_no_err", n_err, 0);
        chk("stall_locked", o_locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive side of the 640x480@60 VGA link that the game top drives.
- Consumes HS/VS/RGB sampled on the 25 MHz pixel strobe and reconstructs pixel coordinates, data-enable and lock status from the sync edges alone.
- Used as an on-chip loopback monitor and frame-capture front end, checking the display path that the game top drives.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC_START, 656, pixel index at which HS asserts
- H_TOTAL, 800, pixel ticks per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC_START, 490, line index at which VS asserts
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to declare lock (1..15)

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel tick enable, one i_clk cycle wide
- i_hs  in  1  horizontal sync, active-low
- i_vs  in  1  vertical sync, active-low
- i_rgb  in  12  {R[3:0],G[3:0],B[3:0]} pixel data
- o_x  out  10  recovered pixel x (0 when !o_de)
- o_y  out  9  recovered pixel y (0 when !o_de)
- o_de  out  1  recovered data-enable
- o_pix_valid  out  1  one-clk pulse per active pixel captured
- o_rgb  out  12  captured pixel (0 when !o_de)
- o_locked  out  1  timing locked
- o_frame_start  out  1  one-clk pulse at pixel (0,0) while locked
- o_err  out  1  one-clk pulse on timing violation while CHECK or LOCKED

Behaviour:
- Single clock, i_clk. Reset is asynchronous and active-low, on i_rst_n.
- Reset values:
  - All outputs 0.
  - hcnt=0, vcnt=0, hs_prev=1, vs_prev=1.
  - State SEARCH, good=0.
- Sampling happens only on tick (i_pix_stb=1). Non-tick cycles hold all state; pulse outputs are 0 on those cycles.
- Edge detection on a tick:
  - hs_fall = hs_prev & ~i_hs; vs_fall = vs_prev & ~i_vs.
  - hs_prev and vs_prev update every tick.
- Next-count values:
  - hn = (hcnt==H_TOTAL-1) ? 0 : hcnt+1.
  - vn = (hn==0) ? ((vcnt==V_TOTAL-1) ? 0 : vcnt+1) : vcnt.
- Counter update on a tick:
  - hcnt <= hs_fall ? H_SYNC_START : hn.
  - vcnt <= vs_fall ? V_SYNC_START : vn.
  - Edges always resynchronise the counters, in every state.
- Violations:
  - h_bad = hs_fall XOR (hn==H_SYNC_START).
  - v_bad = vs_fall XOR (hn==0 && vn==V_SYNC_START).
  - A missing edge and an early or late edge are both violations.
  - bad = h_bad | v_bad, evaluated on ticks only.
- FSM, evaluated on ticks:
  - SEARCH: violations ignored. On vs_fall go to CHECK, good<=0.
  - CHECK: if bad, go to SEARCH and pulse o_err. Else on vs_fall, good<=good+1; when good+1==LOCK_FRAMES go to LOCKED.
  - LOCKED: if bad, go to SEARCH, pulse o_err, and drop o_locked on the same registered update.
  - bad has priority over a lock-completing vs_fall on the same tick.
- o_locked = (state==LOCKED), registered.
- Outputs are registered and update on the i_clk edge that ends the tick cycle, i.e. one i_clk latency from sample to output.
- Per-tick output values (using the post-update hcnt/vcnt):
  - de = locked_next & (hcnt<H_ACTIVE) & (vcnt<V_ACTIVE).
  - o_de <= de.
  - o_x <= de ? hcnt : 0.
  - o_y <= de ? vcnt[8:0] : 0.
  - o_rgb <= de ? i_rgb : 0.
  - o_pix_valid <= de.
  - o_frame_start <= locked_next & hcnt==0 & vcnt==0.
- Coordinates correspond to the pixel whose RGB is sampled on the same tick.
- Width rules:
  - vcnt is 10 bits internally; o_y is its low 9 bits and is valid because V_ACTIVE ≤ 512.
  - good is 4 bits, saturating.
- Reset asserted mid-frame returns everything to reset values immediately; lock must be re-acquired from SEARCH.
- If i_pix_stb stays low indefinitely, all state is frozen; no timeout.

Test Plan:
- Clean stream from the vga timing generator, reset released mid-line, LOCK_FRAMES=2:
  - o_locked=0 through the first vs_fall.
  - o_locked rises on the tick of the 3rd vs_fall.
  - o_err never pulses.
- Locked frame capture:
  - Exactly 307200 o_pix_valid pulses between consecutive o_frame_start pulses.
  - First pulse has o_x=0, o_y=0.
  - Last pulse has o_x=639, o_y=479.
  - o_de=0 at pixel x=640.
  - o_rgb matches i_rgb with 1-clk latency.
- HS shifted one tick late on line 100 while locked:
  - o_err pulses once and o_locked=0 on the same clk.
  - o_de stays 0 until relock at the 3rd following vs_fall.
- VS suppressed for one frame while locked:
  - o_err at the tick where hn==0 && vn==490.
  - State returns to SEARCH.
  - No o_frame_start until relock.
- i_rst_n pulsed low for 2 clks mid-active-line while locked:
  - All outputs 0 asynchronously.
  - o_locked returns only after 3 further vs_falls.
- i_pix_stb held low 50 clks mid-line:
  - o_x and o_y frozen.
  - o_pix_valid=0 throughout.
  - Counting resumes with no o_err.
